// File: rtl/txt_console.sv
// rtl/txt_console.sv - text-page writer: character stream to text RAM with cursor, scroll and clear
//
// Purpose: accepts character codes over a valid/ready handshake and writes them into
// text-page RAM at the cursor. CR moves to the next row, BS steps left, FF clears the page,
// and running off the bottom row scrolls the page up by one row (RAM-to-RAM copy)
// followed by blanking the last row.
//
// Build option: TXT_INTERLEAVE_EN selects the Apple II interleaved row layout
// instead of the linear row layout. Handshake and cycle counts are the same in both builds.
//
// Ports:
//   CLOCK_50   in   system clock, posedge
//   reset      in   synchronous, active-low
//   ch_valid   in   ch_data valid
//   ch_data    in   [7:0] character code
//   ch_ready   out  character accepted on this edge when ch_valid is also high
//   mem_adr    out  [15:0] text RAM address (shared by read and write)
//   mem_d      out  [7:0] text RAM write data
//   mem_we     out  text RAM write enable, one cycle per byte
//   mem_q      in   [7:0] text RAM read data, valid one clock after mem_adr
//   cur_col    out  [5:0] cursor column
//   cur_row    out  [4:0] cursor row
//   busy       out  scroll or clear in progress
module txt_console #(
  parameter int          COLS = 40,
  parameter int          ROWS = 24,
  parameter logic [15:0] BASE = 16'h0400,
  parameter logic [7:0]  FILL = 8'hA0
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic [15:0] mem_adr,
  output logic [7:0]  mem_d,
  output logic        mem_we,
  input  logic [7:0]  mem_q,
  output logic [5:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_PUT, S_SCR_RD, S_SCR_WR, S_CLR} state_t;

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_ack;      // one-cycle hold-off so ready drops after every accept
  logic [7:0]  r_char;
  logic [5:0]  r_col;
  logic [4:0]  r_row;
  logic [5:0]  r_scol;     // scroll/clear walker: source position while scrolling,
  logic [4:0]  r_srow;     // write position while clearing
  logic        w_accept;
  logic        w_walk_end;

  function automatic logic [15:0] f_adr(input logic [4:0] r, input logic [5:0] c);
`ifdef TXT_INTERLEAVE_EN
    f_adr = BASE + {6'd0, r[2:0], 7'd0} + 16'(r[4:3]) * 16'd40 + {10'd0, c};
`else
    f_adr = BASE + 16'(r) * 16'(COLS) + {10'd0, c};
`endif
  endfunction

  assign cur_col    = r_col;
  assign cur_row    = r_row;
  assign w_accept   = ch_valid & ch_ready;
  assign w_walk_end = (r_srow == LAST_ROW) && (r_scol == LAST_COL);

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_char  <= 8'd0;
      r_col   <= 6'd0;
      r_row   <= 5'd0;
      r_scol  <= 6'd0;
      r_srow  <= 5'd0;
    end else begin
      r_state <= w_next;
      r_ack   <= w_accept;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_char <= ch_data;
            case (ch_data)
              8'h0D: begin
                r_col <= 6'd0;
                if (r_row != LAST_ROW) begin
                  r_row <= r_row + 5'd1;
                end else begin
                  r_srow <= 5'd1;
                  r_scol <= 6'd0;
                end
              end
              8'h08: if (r_col != 6'd0) r_col <= r_col - 6'd1;
              8'h0C: begin
                r_col  <= 6'd0;
                r_row  <= 5'd0;
                r_srow <= 5'd0;
                r_scol <= 6'd0;
              end
              default: ;
            endcase
          end
        end
        S_PUT: begin
          if (r_col != LAST_COL) begin
            r_col <= r_col + 6'd1;
          end else begin
            r_col <= 6'd0;
            if (r_row != LAST_ROW) begin
              r_row <= r_row + 5'd1;
            end else begin
              r_srow <= 5'd1;
              r_scol <= 6'd0;
            end
          end
        end
        // The walker stops advancing rows at the last row, so after the final copy
        // it already points at (ROWS-1, 0), which is where the blanking starts.
        S_SCR_WR, S_CLR: begin
          if (r_scol != LAST_COL) begin
            r_scol <= r_scol + 6'd1;
          end else begin
            r_scol <= 6'd0;
            if (r_srow != LAST_ROW) r_srow <= r_srow + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next   = r_state;
    ch_ready = 1'b0;
    mem_adr  = 16'd0;
    mem_d    = 8'd0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    case (r_state)
      S_IDLE: begin
        ch_ready = reset & ~r_ack;
        if (w_accept) begin
          case (ch_data)
            8'h0D:   w_next = (r_row == LAST_ROW) ? S_SCR_RD : S_IDLE;
            8'h08:   w_next = S_IDLE;
            8'h0C:   w_next = S_CLR;
            default: w_next = S_PUT;
          endcase
        end
      end
      S_PUT: begin
        mem_we  = 1'b1;
        mem_adr = f_adr(r_row, r_col);
        mem_d   = r_char;
        w_next  = (r_col == LAST_COL && r_row == LAST_ROW) ? S_SCR_RD : S_IDLE;
      end
      S_SCR_RD: begin
        busy    = 1'b1;
        mem_adr = f_adr(r_srow, r_scol);
        w_next  = S_SCR_WR;
      end
      S_SCR_WR: begin
        busy    = 1'b1;
        mem_we  = 1'b1;
        mem_adr = f_adr(r_srow - 5'd1, r_scol);
        mem_d   = mem_q;
        w_next  = w_walk_end ? S_CLR : S_SCR_RD;
      end
      S_CLR: begin
        busy    = 1'b1;
        mem_we  = 1'b1;
        mem_adr = f_adr(r_srow, r_scol);
        mem_d   = FILL;
        w_next  = w_walk_end ? S_IDLE : S_CLR;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_txt_console.sv
// tb/tb_txt_console.sv - directed table-driven bench for txt_console
module tb_txt_console;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic [15:0] mem_adr;
  logic [7:0]  mem_d;
  logic        mem_we;
  logic [7:0]  mem_q;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  txt_console dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .mem_adr  (mem_adr),
    .mem_d    (mem_d),
    .mem_we   (mem_we),
    .mem_q    (mem_q),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .busy     (busy)
  );

  logic [7:0]  ram [0:65535];
  logic [15:0] wr_adr[$];
  logic [7:0]  wr_d[$];

  always @(posedge CLOCK_50) begin
    if (mem_we) ram[mem_adr] <= mem_d;
    mem_q <= ram[mem_adr];
  end

  always @(posedge CLOCK_50) begin
    if (mem_we) begin
      wr_adr.push_back(mem_adr);
      wr_d.push_back(mem_d);
    end
  end

  function automatic logic [15:0] exp_adr(input int r, input int c);
`ifdef TXT_INTERLEAVE_EN
    exp_adr = 16'(32'h0400 + 128 * (r % 8) + 40 * (r / 8) + c);
`else
    exp_adr = 16'(32'h0400 + 40 * r + c);
`endif
  endfunction

  function automatic logic [7:0] pat(input logic [15:0] a);
    pat = a[7:0] ^ {6'd0, a[9:8]} ^ 8'h5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ch_ready && n < 5000) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
    if (!ch_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic send(input logic [7:0] c);
    wait_ready();
    ch_data  = c;
    ch_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    ch_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(posedge CLOCK_50); #1;
    end
  endtask

  typedef struct {
    logic [7:0] ch;
    logic       we;
    int         wr;
    int         wc;
    int         col;
    int         row;
  } vec_t;

  vec_t vt[10];

  initial begin
    int nb;
    int bad;

    vt[0] = '{8'hC1, 1'b1, 0, 0, 1, 0};
    vt[1] = '{8'h08, 1'b0, 0, 0, 0, 0};
    vt[2] = '{8'h08, 1'b0, 0, 0, 0, 0};
    vt[3] = '{8'hC3, 1'b1, 0, 0, 1, 0};
    vt[4] = '{8'hC4, 1'b1, 0, 1, 2, 0};
    vt[5] = '{8'h0D, 1'b0, 0, 0, 0, 1};
    vt[6] = '{8'hC5, 1'b1, 1, 0, 1, 1};
    vt[7] = '{8'h08, 1'b0, 0, 0, 0, 1};
    vt[8] = '{8'h0D, 1'b0, 0, 0, 0, 2};
    vt[9] = '{8'hC6, 1'b1, 2, 0, 1, 2};

    ch_valid = 1'b0;
    ch_data  = 8'd0;
    reset    = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("rst_ready", ch_ready, 0);
    chk("rst_we",    mem_we,   0);
    chk("rst_adr",   mem_adr,  0);
    chk("rst_d",     mem_d,    0);
    chk("rst_col",   cur_col,  0);
    chk("rst_row",   cur_row,  0);
    chk("rst_busy",  busy,     0);
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("ready_after_rst", ch_ready, 1);

    for (int i = 0; i < 10; i++) begin
      send(vt[i].ch);
      chk($sformatf("v%0d_we", i), mem_we, vt[i].we);
      if (vt[i].we) begin
        chk($sformatf("v%0d_adr", i), mem_adr, exp_adr(vt[i].wr, vt[i].wc));
        chk($sformatf("v%0d_d", i),   mem_d,   vt[i].ch);
      end
      chk($sformatf("v%0d_ready_low", i), ch_ready, 0);
      @(posedge CLOCK_50); #1;
      chk($sformatf("v%0d_ready_back", i), ch_ready, 1);
      chk($sformatf("v%0d_we_off", i),     mem_we,   0);
      chk($sformatf("v%0d_col", i),        cur_col,  vt[i].col);
      chk($sformatf("v%0d_row", i),        cur_row,  vt[i].row);
    end

    // Last column of row 0 wraps to the start of row 1.
    send(8'h0C);
    count_busy(nb);
    for (int i = 0; i < 39; i++) send(8'hC0);
    send(8'hC2);
    chk("wrap_we",  mem_we,  1);
    chk("wrap_adr", mem_adr, exp_adr(0, 39));
    chk("wrap_d",   mem_d,   8'hC2);
    @(posedge CLOCK_50); #1;
    chk("wrap_col", cur_col, 0);
    chk("wrap_row", cur_row, 1);

    // Backspace from column 7.
    for (int i = 0; i < 7; i++) send(8'hC0);
    wait_ready();
    chk("bs_pre_col", cur_col, 7);
    send(8'h08);
    chk("bs_we", mem_we, 0);
    @(posedge CLOCK_50); #1;
    chk("bs_col", cur_col, 6);
    chk("bs_row", cur_row, 1);

    // Form feed clears the whole page.
    wait_ready();
    wr_adr.delete();
    wr_d.delete();
    send(8'h0C);
    chk("ff_busy", busy, 1);
    count_busy(nb);
    chk("ff_cycles", nb, 960);
    chk("ff_writes", wr_adr.size(), 960);
    bad = 0;
    for (int i = 0; i < wr_adr.size() && i < 960; i++)
      if (wr_adr[i] !== exp_adr(i / 40, i % 40) || wr_d[i] !== 8'hA0) bad++;
    chk("ff_bad_writes", bad, 0);
    chk("ff_col", cur_col, 0);
    chk("ff_row", cur_row, 0);

    // Position at (5,23), preload a pattern, then CR forces a scroll.
    for (int i = 0; i < 23; i++) send(8'h0D);
    for (int i = 0; i < 5; i++) send(8'hC7);
    wait_ready();
    chk("pos_col", cur_col, 5);
    chk("pos_row", cur_row, 23);
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 40; c++)
        ram[exp_adr(r, c)] = pat(exp_adr(r, c));
    wr_adr.delete();
    wr_d.delete();
    send(8'h0D);
    chk("scr_busy",    busy,     1);
    chk("scr_ready",   ch_ready, 0);
    count_busy(nb);
    chk("scr_cycles",  nb, 1880);
    chk("scr_writes",  wr_adr.size(), 960);
    chk("scr_row0_c0", ram[exp_adr(0, 0)],  pat(exp_adr(1, 0)));
    chk("scr_row0_c39", ram[exp_adr(0, 39)], pat(exp_adr(1, 39)));
    bad = 0;
    for (int r = 0; r < 23; r++)
      for (int c = 0; c < 40; c++)
        if (ram[exp_adr(r, c)] !== pat(exp_adr(r + 1, c))) bad++;
    chk("scr_copy_bad", bad, 0);
    bad = 0;
    for (int c = 0; c < 40; c++)
      if (ram[exp_adr(23, c)] !== 8'hA0) bad++;
    chk("scr_blank_bad", bad, 0);
    chk("scr_col",   cur_col,  0);
    chk("scr_row",   cur_row,  23);
    chk("scr_ready_back", ch_ready, 1);

    // Reset in the middle of a scroll.
    send(8'h0D);
    repeat (100) @(posedge CLOCK_50);
    #1;
    chk("mid_busy", busy, 1);
    reset = 1'b0;
    @(posedge CLOCK_50); #1;
    chk("abort_we",    mem_we,   0);
    chk("abort_busy",  busy,     0);
    chk("abort_col",   cur_col,  0);
    chk("abort_row",   cur_row,  0);
    chk("abort_ready", ch_ready, 0);
    chk("abort_adr",   mem_adr,  0);
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("abort_ready_back", ch_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
